seven_segment_scan_decoder: RTL and testbench

//  Reader for the multiplexed 4-digit seven-segment bus (seg active-low, an active-low one-hot).

---
 rtl/seven_segment_scan_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_seven_segment_scan_decoder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder
//   Reads a multiplexed 4-digit seven-segment bus and recovers the digit codes.
//   It waits for each digit slot to settle and inverts the segment pattern back to a 4-bit code.
//   It then publishes one coherent 4-digit frame per full scan.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   seg[6:0]        segment lines, active-low, bit6=g .. bit0=a
//   an[3:0]         digit enables, active-low one-hot; an[0]=min_ones .. an[3]=hrs_tens
//   err_clr         clears the sticky error flags
//   min_ones..hrs_tens  decoded digits of the last complete frame
//   frame_valid     1-cycle pulse when the digit outputs update
//   frame_changed   pulses with frame_valid when the frame differs from the previous one
//   pattern_err     sticky: a settled segment pattern was not a known glyph
//   an_err          sticky: a settled enable pattern was neither one-hot-low nor blank
//   scan_stall      level: 'an' has not changed for STALL_CYCLES cycles
module seven_segment_scan_decoder #(
  parameter int STABLE_CYCLES = 16,        // >= 2
  parameter int STALL_CYCLES  = 1_000_000  // >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  input  logic       err_clr,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hrs_ones,
  output logic [3:0] hrs_tens,
  output logic       frame_valid,
  output logic       frame_changed,
  output logic       pattern_err,
  output logic       an_err,
  output logic       scan_stall
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int SW = $clog2(STALL_CYCLES);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_CYCLES - 1);

  localparam logic [1:0] WAIT_SEL = 2'd0;
  localparam logic [1:0] SETTLE   = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;

  // Returns {known, code} for an active-low segment pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b1000000: res = {1'b1, 4'h0};
      7'b1111001: res = {1'b1, 4'h1};
      7'b0100100: res = {1'b1, 4'h2};
      7'b0110000: res = {1'b1, 4'h3};
      7'b0011001: res = {1'b1, 4'h4};
      7'b0010010: res = {1'b1, 4'h5};
      7'b0000010: res = {1'b1, 4'h6};
      7'b1111000: res = {1'b1, 4'h7};
      7'b0000000: res = {1'b1, 4'h8};
      7'b0011000: res = {1'b1, 4'h9};
      7'b0001000: res = {1'b1, 4'hA};
      7'b0000011: res = {1'b1, 4'hB};
      7'b1000110: res = {1'b1, 4'hC};
      7'b0100001: res = {1'b1, 4'hD};
      7'b0000110: res = {1'b1, 4'hE};
      7'b0001110: res = {1'b1, 4'hF};
      default:    res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  // Returns {one_hot_low, index} for the digit-enable lines.
  function automatic logic [2:0] an_select(input logic [3:0] sel);
    logic [2:0] res;
    case (sel)
      4'b1110: res = {1'b1, 2'd0};
      4'b1101: res = {1'b1, 2'd1};
      4'b1011: res = {1'b1, 2'd2};
      4'b0111: res = {1'b1, 2'd3};
      default: res = {1'b0, 2'd0};
    endcase
    return res;
  endfunction

  logic [6:0]      seg_meta_r, seg_sync_r, seg_prev_r;
  logic [3:0]      an_meta_r, an_sync_r, an_prev_r;
  logic [CW-1:0]   stab_cnt_r, stab_cnt_nxt_s;
  logic [SW-1:0]   stall_cnt_r, stall_cnt_nxt_s;
  logic [1:0]      state_r, state_nxt_s;
  logic [3:0]      seen_r, newbit_s;
  logic [3:0][3:0] shadow_r, shadow_nxt_s;
  logic            first_r;
  logic            sample_chg_s, an_chg_s, settled_s, act_s;
  logic            capture_s, cap_ok_s, pat_set_s, an_set_s, frame_s;
  logic [4:0]      dec_s;
  logic [2:0]      sel_s;

  // Next-state, capture and counter decisions; prev_r holds the sample being judged.
  always_comb begin
    sample_chg_s = ({an_sync_r, seg_sync_r} != {an_prev_r, seg_prev_r});
    an_chg_s     = (an_sync_r != an_prev_r);
    settled_s    = (stab_cnt_r == SETTLE_MAX);
    dec_s        = seg_decode(seg_prev_r);
    sel_s        = an_select(an_prev_r);
    act_s        = 1'b0;
    state_nxt_s  = state_r;
    case (state_r)
      WAIT_SEL, HOLD: begin
        if (sample_chg_s) state_nxt_s = SETTLE;
        else              state_nxt_s = state_r;
      end
      SETTLE: begin
        // A change landing on the settle cycle starts the next slot immediately.
        if (settled_s) begin
          act_s       = 1'b1;
          state_nxt_s = sample_chg_s ? SETTLE : HOLD;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      default: state_nxt_s = WAIT_SEL;
    endcase

    capture_s    = act_s & sel_s[2];
    cap_ok_s     = capture_s & dec_s[4];
    pat_set_s    = capture_s & ~dec_s[4];
    an_set_s     = act_s & ~sel_s[2] & (an_prev_r != 4'hF);
    newbit_s     = 4'b0000;
    shadow_nxt_s = shadow_r;
    if (cap_ok_s) begin
      newbit_s[sel_s[1:0]]     = 1'b1;
      shadow_nxt_s[sel_s[1:0]] = dec_s[3:0];
    end else begin
      newbit_s = 4'b0000;
    end
    frame_s = cap_ok_s & ((seen_r | newbit_s) == 4'b1111);

    if (sample_chg_s)              stab_cnt_nxt_s = {CW{1'b0}};
    else if (stab_cnt_r == SETTLE_MAX) stab_cnt_nxt_s = stab_cnt_r;
    else                           stab_cnt_nxt_s = stab_cnt_r + {{(CW-1){1'b0}}, 1'b1};

    if (an_chg_s)                  stall_cnt_nxt_s = {SW{1'b0}};
    else if (stall_cnt_r == STALL_MAX) stall_cnt_nxt_s = stall_cnt_r;
    else                           stall_cnt_nxt_s = stall_cnt_r + {{(SW-1){1'b0}}, 1'b1};
  end

  // Input synchronizers, previous-sample register and the two counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_meta_r  <= 7'h7F;
      seg_sync_r  <= 7'h7F;
      seg_prev_r  <= 7'h7F;
      an_meta_r   <= 4'hF;
      an_sync_r   <= 4'hF;
      an_prev_r   <= 4'hF;
      stab_cnt_r  <= {CW{1'b0}};
      stall_cnt_r <= {SW{1'b0}};
      scan_stall  <= 1'b0;
    end else begin
      seg_meta_r  <= seg;
      seg_sync_r  <= seg_meta_r;
      seg_prev_r  <= seg_sync_r;
      an_meta_r   <= an;
      an_sync_r   <= an_meta_r;
      an_prev_r   <= an_sync_r;
      stab_cnt_r  <= stab_cnt_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
      scan_stall  <= (stall_cnt_nxt_s >= STALL_MAX);
    end
  end

  // Slot FSM, shadow digits, frame publication and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= WAIT_SEL;
      seen_r        <= 4'b0000;
      shadow_r      <= {16{1'b0}};
      first_r       <= 1'b1;
      min_ones      <= 4'h0;
      min_tens      <= 4'h0;
      hrs_ones      <= 4'h0;
      hrs_tens      <= 4'h0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      pattern_err   <= 1'b0;
      an_err        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shadow_r    <= shadow_nxt_s;
      frame_valid <= frame_s;
      if (frame_s) begin
        {hrs_tens, hrs_ones, min_tens, min_ones} <= shadow_nxt_s;
        frame_changed <= first_r | (shadow_nxt_s != {hrs_tens, hrs_ones, min_tens, min_ones});
        first_r       <= 1'b0;
        seen_r        <= 4'b0000;
      end else begin
        frame_changed <= 1'b0;
        seen_r        <= seen_r | newbit_s;
      end
      // A set event in the clearing cycle keeps the flag high.
      pattern_err <= pat_set_s | (pattern_err & ~err_clr);
      an_err      <= an_set_s | (an_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Self-checking bench for seven_segment_scan_decoder.
// A slot-level reference model turns each driven {an,seg} segment into expected
// captures, frames and error flags; the DUT's published frames are collected and
// compared in order.
module tb_seven_segment_scan_decoder;

  localparam int STABLE = 16;
  localparam int STALL  = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg = 7'h7F;
  logic [3:0] an  = 4'hF;
  logic       err_clr = 1'b0;
  logic [3:0] min_ones, min_tens, hrs_ones, hrs_tens;
  logic       frame_valid, frame_changed, pattern_err, an_err, scan_stall;

  seven_segment_scan_decoder #(.STABLE_CYCLES(STABLE), .STALL_CYCLES(STALL)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an), .err_clr(err_clr),
    .min_ones(min_ones), .min_tens(min_tens), .hrs_ones(hrs_ones), .hrs_tens(hrs_tens),
    .frame_valid(frame_valid), .frame_changed(frame_changed),
    .pattern_err(pattern_err), .an_err(an_err), .scan_stall(scan_stall)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // glyph table: index = code, value = active-low segments g..a
  logic [6:0] pat_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // reference model state; frame entries are {changed, hrs_tens, hrs_ones, min_tens, min_ones}
  logic [3:0]  m_seen;
  logic [3:0]  m_shadow [4];
  logic        m_first;
  logic [15:0] m_last;
  logic        m_pat_err, m_an_err;
  logic [16:0] exp_q [$];
  logic [16:0] obs_q [$];

  always @(negedge clk)
    if (!rst && frame_valid)
      obs_q.push_back({frame_changed, hrs_tens, hrs_ones, min_tens, min_ones});

  function automatic void model_reset();
    m_seen = 4'b0000;
    for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
    m_first = 1'b1;
    m_last = 16'h0000;
    m_pat_err = 1'b0;
    m_an_err = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endfunction

  // One settled slot: what the display would show and what the reader must make of it.
  function automatic void model_slot(input logic [3:0] a, input logic [6:0] s);
    int idx = -1;
    int code = -1;
    logic [3:0] oh;
    logic [15:0] frame;
    for (int i = 0; i < 4; i++) begin
      oh = 4'b0001 << i;
      if (a == ~oh) idx = i;
    end
    for (int c = 0; c < 16; c++) if (pat_tab[c] == s) code = c;
    if (a == 4'hF) return;
    if (idx < 0) begin m_an_err = 1'b1; return; end
    if (code < 0) begin m_pat_err = 1'b1; return; end
    m_shadow[idx] = 4'(code);
    m_seen[idx] = 1'b1;
    if (m_seen == 4'hF) begin
      frame = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
      exp_q.push_back({m_first || (frame != m_last), frame});
      m_last = frame;
      m_first = 1'b0;
      m_seen = 4'b0000;
    end
  endfunction

  // Hold {an,seg} for dur cycles; segments shorter than the settle window are glitches.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int dur);
    an = a;
    seg = s;
    if (dur > STABLE + 2) model_slot(a, s);
    repeat (dur) @(negedge clk);
  endtask

  task automatic scan4(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                       input logic [3:0] d0, input int dur);
    drive(4'b0111, pat_tab[d3], dur);
    drive(4'b1011, pat_tab[d2], dur);
    drive(4'b1101, pat_tab[d1], dur);
    drive(4'b1110, pat_tab[d0], dur);
    drive(4'b1111, 7'h7F, 30);
  endtask

  task automatic test_reset;
    rst = 1'b1; an = 4'hF; seg = 7'h7F; err_clr = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    compared++;
    if ({hrs_tens, hrs_ones, min_tens, min_ones} !== 16'h0000) begin
      mismatched++; $display("FAIL reset_digits: got %h expected 0000", {hrs_tens, hrs_ones, min_tens, min_ones});
    end
    compared++;
    if ({frame_valid, frame_changed, pattern_err, an_err, scan_stall} !== 5'b00000) begin
      mismatched++; $display("FAIL reset_flags: got %b expected 00000", {frame_valid, frame_changed, pattern_err, an_err, scan_stall});
    end
  endtask

  task automatic test_first_frame;
    scan4(4'h1, 4'h2, 4'h3, 4'h4, 200);
    compared++;
    if (obs_q.size() != 1) begin
      mismatched++; $display("FAIL first_frame_count: got %0d expected 1", obs_q.size());
    end else begin
      compared++;
      if (obs_q[0] !== 17'h11234) begin
        mismatched++; $display("FAIL first_frame_value: got %h expected 11234", obs_q[0]);
      end
    end
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL first_model_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_repeat;
    scan4(4'h1, 4'h2, 4'h3, 4'h4, 200);
    scan4(4'h1, 4'h2, 4'h3, 4'h4, 200);
    scan4(4'h1, 4'h2, 4'h3, 4'h5, 200);
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL repeat_count: got %0d frames expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      compared++;
      if (obs_q[i] !== exp_q[i]) begin
        mismatched++; $display("FAIL repeat_frame[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() == 3) begin
      compared++;
      if ({obs_q[0][16], obs_q[1][16], obs_q[2][16]} !== 3'b001) begin
        mismatched++; $display("FAIL repeat_changed: got %b expected 001", {obs_q[0][16], obs_q[1][16], obs_q[2][16]});
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch;
    drive(4'b0111, pat_tab[2], 60);
    drive(4'b1011, pat_tab[7], 60);
    drive(4'b1011, pat_tab[8], 5);
    drive(4'b1011, pat_tab[7], 60);
    drive(4'b1101, pat_tab[0], 60);
    drive(4'b1110, pat_tab[9], 60);
    drive(4'b1111, 7'h7F, 30);
    compared++;
    if (pattern_err !== 1'b0) begin
      mismatched++; $display("FAIL glitch_pattern_err: got %b expected 0", pattern_err);
    end
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL glitch_count: got %0d frames expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      compared++;
      if (obs_q[i] !== exp_q[i]) begin
        mismatched++; $display("FAIL glitch_frame[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    logic [3:0] dig [4];
    logic [3:0] sel;
    int start, k;
    for (int s = 0; s < 8; s++) begin
      if (s == 0 || $urandom_range(0, 2) != 0)
        for (int i = 0; i < 4; i++) dig[i] = 4'($urandom_range(0, 15));
      start = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        k = (start + i) % 4;
        sel = 4'b0001 << k;
        drive(~sel, pat_tab[dig[k]], $urandom_range(30, 120));
        if (i < 3 && $urandom_range(0, 3) == 0) drive(4'hF, 7'h7F, 30);
      end
      drive(4'hF, 7'h7F, 30);
    end
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL random_count: got %0d frames expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      compared++;
      if (obs_q[i] !== exp_q[i]) begin
        mismatched++; $display("FAIL random_frame[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    compared++;
    if ({pattern_err, an_err, scan_stall} !== {m_pat_err, m_an_err, 1'b0}) begin
      mismatched++; $display("FAIL random_flags: got %b expected %b", {pattern_err, an_err, scan_stall}, {m_pat_err, m_an_err, 1'b0});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_errors;
    drive(4'b1110, 7'b1111111, 40);
    compared++;
    if ({pattern_err, an_err} !== {m_pat_err, m_an_err}) begin
      mismatched++; $display("FAIL err_pattern: got %b expected %b", {pattern_err, an_err}, {m_pat_err, m_an_err});
    end
    drive(4'b1100, pat_tab[3], 40);
    compared++;
    if ({pattern_err, an_err} !== {m_pat_err, m_an_err}) begin
      mismatched++; $display("FAIL err_an: got %b expected %b", {pattern_err, an_err}, {m_pat_err, m_an_err});
    end
    compared++;
    if (obs_q.size() != 0) begin
      mismatched++; $display("FAIL err_no_frame: got %0d frames expected 0", obs_q.size());
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_pat_err = 1'b0; m_an_err = 1'b0;
    @(negedge clk);
    compared++;
    if ({pattern_err, an_err} !== {m_pat_err, m_an_err}) begin
      mismatched++; $display("FAIL err_clear: got %b expected %b", {pattern_err, an_err}, {m_pat_err, m_an_err});
    end
  endtask

  task automatic test_stall;
    drive(4'b1110, pat_tab[9], 250);
    compared++;
    if (scan_stall !== 1'b0) begin
      mismatched++; $display("FAIL stall_early: got %b expected 0", scan_stall);
    end
    repeat (100) @(negedge clk);
    compared++;
    if (scan_stall !== 1'b1) begin
      mismatched++; $display("FAIL stall_set: got %b expected 1", scan_stall);
    end
    an = 4'b1101; seg = pat_tab[6];
    model_slot(4'b1101, pat_tab[6]);
    repeat (4) @(negedge clk);
    compared++;
    if (scan_stall !== 1'b0) begin
      mismatched++; $display("FAIL stall_drop: got %b expected 0", scan_stall);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL midreset_pre: got %0d frames expected %0d", obs_q.size(), exp_q.size());
    end
    an = 4'hF; seg = 7'h7F; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    compared++;
    if ({hrs_tens, hrs_ones, min_tens, min_ones, frame_valid, pattern_err, an_err, scan_stall} !== 20'h00000) begin
      mismatched++; $display("FAIL midreset_outputs: got %h expected 00000",
        {hrs_tens, hrs_ones, min_tens, min_ones, frame_valid, pattern_err, an_err, scan_stall});
    end
    drive(4'b1110, pat_tab[6], 60);
    drive(4'b1101, pat_tab[5], 60);
    drive(4'hF, 7'h7F, 30);
    compared++;
    if (obs_q.size() != 0) begin
      mismatched++; $display("FAIL midreset_partial: got %0d frames expected 0", obs_q.size());
    end
    drive(4'b0111, pat_tab[1], 60);
    drive(4'b1011, pat_tab[4], 60);
    drive(4'hF, 7'h7F, 30);
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL midreset_count: got %0d frames expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      compared++;
      if (obs_q[i] !== exp_q[i]) begin
        mismatched++; $display("FAIL midreset_frame[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_frame();
    test_repeat();
    test_glitch();
    test_random();
    test_errors();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
